eth_pkt_tagger: RTL
===================

ETH_PKT_TAGGER -- requirements
Module: eth_pkt_tagger

Interface
REQ-001 SHALL have port: clk_clk  in  1  sole clock, all logic rising-edge.
REQ-002 SHALL have port: reset_reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_data  in  128; in_valid  in  1; in_ready  out  1; in_startofpacket  in  1; in_endofpacket  in  1; in_empty  in  4; in_channel  in  8. These form the Avalon-ST sink fed by the 4-to-1 Ethernet mux output.
REQ-004 SHALL have ports: out_data  out  128; out_valid  out  1; out_ready  in  1; out_startofpacket  out  1; out_endofpacket  out  1; out_empty  out  4; out_channel  out  8. These form the Avalon-ST source and forward the stream unchanged.
REQ-005 SHALL have ports: tag_data  out  10; tag_valid  out  1; tag_ready  in  1. This is the per-packet descriptor source feeding the ethpack tag input.
REQ-006 SHALL have port: err_count  out  8  saturating framing-error count.
REQ-007 SHALL have port: pkt_count  out  32  completed-packet count (see Configuration).

Function
REQ-008 A beat SHALL be accepted when in_valid && in_ready.
REQ-009 The data path SHALL be one register stage: an accepted beat appears on out_* the next cycle, and all fields are preserved bit-exact.
REQ-010 in_ready SHALL = (!out_valid || out_ready) && !(tag_full && in_endofpacket).
REQ-011 out_valid SHALL hold, with out_* stable, until out_ready is high.
REQ-012 The FSM SHALL have states IDLE and IN_PKT, with a beat counter cnt[7:0] that saturates at 255.
REQ-013 IDLE, accepted SOP&&EOP: the block SHALL push tag {in_channel[1:0], 8'd1} and stay in IDLE.
REQ-014 IDLE, accepted SOP&&!EOP: cnt SHALL be set to 1 and the FSM SHALL go to IN_PKT.
REQ-015 IDLE, accepted beat without SOP: the beat SHALL still be forwarded, err_count SHALL increment, and no tag SHALL be pushed.
REQ-016 IN_PKT, accepted !SOP&&!EOP: cnt SHALL increment (saturating).
REQ-017 IN_PKT, accepted !SOP&&EOP: the block SHALL push tag {latched channel[1:0], sat(cnt+1)} and go to IDLE.
REQ-018 IN_PKT, accepted SOP: err_count SHALL increment and the open packet's tag SHALL be discarded. The new packet SHALL then start as if in IDLE, per REQ-013/014.
REQ-019 The channel SHALL be latched on the SOP beat, and in_channel on non-SOP beats SHALL be ignored.
REQ-020 The tag FIFO SHALL be 8 deep, first-word fall-through, with tag_valid = !empty.
REQ-021 A tag SHALL pop on tag_valid && tag_ready.
REQ-022 On a simultaneous push and pop, both SHALL occur and the occupancy SHALL be unchanged.
REQ-023 tag_full SHALL reflect registered occupancy == 8, and a same-cycle pop SHALL NOT relieve it.
REQ-024 err_count SHALL saturate at 255.

Reset
REQ-025 While reset_reset is high at a clock edge, the block SHALL force out_valid=0, tag_valid=0, FIFO empty, FSM=IDLE, cnt=0, err_count=0 and pkt_count=0.
REQ-026 in_ready SHALL be 0 during reset and SHALL be valid the cycle after release.
REQ-027 A reset during IN_PKT SHALL drop the partial packet without a tag and without an error.

Configuration
REQ-028 The macro ETH_PKT_TAGGER_STATS_EN SHALL control packet statistics.
REQ-029 With ETH_PKT_TAGGER_STATS_EN defined, pkt_count SHALL increment (wrapping at 2^32) on every tag push.
REQ-030 Without ETH_PKT_TAGGER_STATS_EN, pkt_count SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-031 Stimulus: single-beat packet, channel 8'h02, out_ready=1, tag_ready=1. Response: out beat after 1 cycle, tag_data=10'h201, pkt_count=1 (macro on).
REQ-032 Stimulus: 4-beat packet on channel 3, then 300-beat packet on channel 1. Response: tags 10'h304 then 10'h1FF.
REQ-033 Stimulus: tag_ready=0, nine 1-beat packets back-to-back. Response: eight tags queued, in_ready=0 on the ninth EOP beat. Raising tag_ready SHALL let the ninth beat be accepted, and the ninth tag SHALL follow.
REQ-034 Stimulus: SOP, 2 beats, SOP again, then EOP. Response: err_count=1, a single tag with count 2 for the second packet.
REQ-035 Stimulus: out_ready toggled 1/0 every cycle across a 10-beat packet. Response: no beat lost or duplicated, out_* stable while stalled, tag count 10.
REQ-036 Stimulus: reset_reset pulsed mid-packet after 3 beats, then a 2-beat packet. Response: no tag for the partial packet, err_count=0, one tag with count 2.

Source files
------------

// File: rtl/eth_pkt_tagger.sv
// Avalon-ST pass-through that emits a 10-bit {channel, beat count} tag per packet.
// Define ETH_PKT_TAGGER_STATS_EN to build the completed-packet counter on pkt_count.
module eth_pkt_tagger (
    input  logic         clk_clk,
    input  logic         reset_reset,

    input  logic [127:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_startofpacket,
    input  logic         in_endofpacket,
    input  logic [3:0]   in_empty,
    input  logic [7:0]   in_channel,

    output logic [127:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_startofpacket,
    output logic         out_endofpacket,
    output logic [3:0]   out_empty,
    output logic [7:0]   out_channel,

    output logic [9:0]   tag_data,
    output logic         tag_valid,
    input  logic         tag_ready,

    output logic [7:0]   err_count,
    output logic [31:0]  pkt_count
);

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

    state_t       state_q;
    logic [7:0]   cnt_q;
    logic [1:0]   chan_q;
    logic [7:0]   errCount_q;

    logic [127:0] outData_q;
    logic         outValid_q;
    logic         outSop_q;
    logic         outEop_q;
    logic [3:0]   outEmpty_q;
    logic [7:0]   outChannel_q;

    logic [9:0]   tagMem_q [8];
    logic [2:0]   wrPtr_q;
    logic [2:0]   rdPtr_q;
    logic [3:0]   tagCount_q;

    logic         accept;
    logic         tagFull;
    logic         tagPush;
    logic         tagPop;
    logic [9:0]   tagWord;
    logic         errInc;
    logic [7:0]   cntInc;

    // Backpressure only on EOP beats when full, since only those push a tag.
    assign tagFull  = (tagCount_q == 4'd8);
    assign in_ready = !reset_reset && (!outValid_q || out_ready)
                      && !(tagFull && in_endofpacket);
    assign accept   = in_valid && in_ready;
    assign cntInc   = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
    assign tagPop   = (tagCount_q != 4'd0) && tag_ready;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            outValid_q <= 1'b0;
        end else if (accept) begin
            outValid_q <= 1'b1;
        end else if (out_ready) begin
            outValid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (accept) begin
            outData_q    <= in_data;
            outSop_q     <= in_startofpacket;
            outEop_q     <= in_endofpacket;
            outEmpty_q   <= in_empty;
            outChannel_q <= in_channel;
        end
    end

    always_comb begin
        tagPush = 1'b0;
        tagWord = 10'd0;
        errInc  = 1'b0;
        if (accept) begin
            if (in_startofpacket) begin
                errInc = (state_q == IN_PKT);
                if (in_endofpacket) begin
                    tagPush = 1'b1;
                    tagWord = {in_channel[1:0], 8'd1};
                end
            end else if (state_q == IDLE) begin
                errInc = 1'b1;
            end else if (in_endofpacket) begin
                tagPush = 1'b1;
                tagWord = {chan_q, cntInc};
            end
        end
    end

    // A new SOP simply restarts the packet, abandoning any open one.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            chan_q     <= 2'd0;
            errCount_q <= 8'd0;
        end else if (accept) begin
            if (in_startofpacket) begin
                chan_q <= in_channel[1:0];
                if (in_endofpacket) begin
                    state_q <= IDLE;
                end else begin
                    state_q <= IN_PKT;
                    cnt_q   <= 8'd1;
                end
            end else if (state_q == IN_PKT) begin
                if (in_endofpacket) begin
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cntInc;
                end
            end
            if (errInc && (errCount_q != 8'hFF)) begin
                errCount_q <= errCount_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (tagPush) begin
            tagMem_q[wrPtr_q] <= tagWord;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wrPtr_q    <= 3'd0;
            rdPtr_q    <= 3'd0;
            tagCount_q <= 4'd0;
        end else begin
            if (tagPush) begin
                wrPtr_q <= wrPtr_q + 3'd1;
            end
            if (tagPop) begin
                rdPtr_q <= rdPtr_q + 3'd1;
            end
            case ({tagPush, tagPop})
                2'b10:   tagCount_q <= tagCount_q + 4'd1;
                2'b01:   tagCount_q <= tagCount_q - 4'd1;
                default: tagCount_q <= tagCount_q;
            endcase
        end
    end

`ifdef ETH_PKT_TAGGER_STATS_EN
    logic [31:0] pktCount_q;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            pktCount_q <= 32'd0;
        end else if (tagPush) begin
            pktCount_q <= pktCount_q + 32'd1;
        end
    end

    assign pkt_count = pktCount_q;
`else
    assign pkt_count = 32'd0;
`endif

    assign out_data          = outData_q;
    assign out_valid         = outValid_q;
    assign out_startofpacket = outSop_q;
    assign out_endofpacket   = outEop_q;
    assign out_empty         = outEmpty_q;
    assign out_channel       = outChannel_q;

    assign tag_data  = tagMem_q[rdPtr_q];
    assign tag_valid = (tagCount_q != 4'd0);
    assign err_count = errCount_q;

endmodule
